// File: rtl/cfg_demux_if.sv
// ---------------------------------------------------------------------------
// cfg_demux_if
//   Pin-side bundle of the configuration demultiplexer.
//   master : host side, drives din/addr/wr_stb/ld_stb and observes results.
//   slave  : cfg_demux side.
//   Signals
//     din          write data byte from the pins
//     addr         byte select 0..3 for the write
//     wr_stb       asynchronous write strobe (rising edge acts)
//     ld_stb       asynchronous load strobe (rising edge acts)
//     q0..q3       active configuration registers
//     all_written  all four shadow bytes written since reset
//     wr_cnt       accepted write count, wraps 255 -> 0
//     rd_data      shadow readback (zero when readback is not built)
// ---------------------------------------------------------------------------
interface cfg_demux_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic [1:0]        addr;
    logic              wr_stb;
    logic              ld_stb;
    logic [DATA_W-1:0] q0;
    logic [DATA_W-1:0] q1;
    logic [DATA_W-1:0] q2;
    logic [DATA_W-1:0] q3;
    logic              all_written;
    logic [7:0]        wr_cnt;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output din, addr, wr_stb, ld_stb,
        input  q0, q1, q2, q3, all_written, wr_cnt, rd_data
    );

    modport slave (
        input  din, addr, wr_stb, ld_stb,
        output q0, q1, q2, q3, all_written, wr_cnt, rd_data
    );
endinterface

// File: rtl/cfg_demux.sv
// ---------------------------------------------------------------------------
// cfg_demux
//   Routes bytes from the input pins into four configuration registers.
//   Pin strobes are synchronised and edge-detected; each write edge stores
//   one byte in a shadow bank, each load edge copies the whole shadow bank
//   into the active bank (q0..q3) in a single cycle.
//   Optional feature macro: CFG_DEMUX_READBACK_EN
//     defined   : rd_data is a registered readback of shadow[addr]
//     undefined : rd_data is tied to zero
//   Ports
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    cfg_demux_if.slave (din, addr, wr_stb, ld_stb, q0..q3,
//            all_written, wr_cnt, rd_data)
// ---------------------------------------------------------------------------
module cfg_demux #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic      clk,
    input  logic      rst_n,
    cfg_demux_if.slave bus
);
    localparam int S = SYNC_STAGES;

    // Strobe synchronisers, edge history and arming
    logic [S-1:0] wr_sync_q, ld_sync_q;
    logic         wr_prev_q, ld_prev_q;
    logic         sampled_q;
    logic         wr_armed_q, ld_armed_q;

    // din/addr delay line, same depth as the strobe synchronisers
    logic [DATA_W-1:0] din_pipe_q  [S];
    logic [1:0]        addr_pipe_q [S];

    logic [3:0][DATA_W-1:0] shadow_q, shadow_d;
    logic [3:0][DATA_W-1:0] act_q, act_d;
    logic [3:0]             mask_q, mask_d;
    logic                   aw_q, aw_d;
    logic [7:0]             cnt_q, cnt_d;

    logic              wr_sync, ld_sync;
    logic              wr_edge, ld_edge;
    logic [DATA_W-1:0] din_dly;
    logic [1:0]        addr_dly;

    assign wr_sync  = wr_sync_q[S-1];
    assign ld_sync  = ld_sync_q[S-1];
    assign din_dly  = din_pipe_q[S-1];
    assign addr_dly = addr_pipe_q[S-1];

    // A strobe only becomes armed once a low level has been sampled after
    // reset, so a strobe held high across reset release never fires.
    assign wr_edge = wr_sync & ~wr_prev_q & wr_armed_q;
    assign ld_edge = ld_sync & ~ld_prev_q & ld_armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sync_q  <= '0;
            ld_sync_q  <= '0;
            wr_prev_q  <= 1'b0;
            ld_prev_q  <= 1'b0;
            sampled_q  <= 1'b0;
            wr_armed_q <= 1'b0;
            ld_armed_q <= 1'b0;
        end else begin
            wr_sync_q  <= {wr_sync_q[S-2:0], bus.wr_stb};
            ld_sync_q  <= {ld_sync_q[S-2:0], bus.ld_stb};
            wr_prev_q  <= wr_sync;
            ld_prev_q  <= ld_sync;
            sampled_q  <= 1'b1;
            // stage 0 holds a genuine pin sample only once sampled_q is set
            wr_armed_q <= wr_armed_q | (sampled_q & ~wr_sync_q[0]);
            ld_armed_q <= ld_armed_q | (sampled_q & ~ld_sync_q[0]);
        end
    end

    // Data delay line carries no control meaning, so it is not reset
    always_ff @(posedge clk) begin
        din_pipe_q[0]  <= bus.din;
        addr_pipe_q[0] <= bus.addr;
        for (int i = 1; i < S; i++) begin
            din_pipe_q[i]  <= din_pipe_q[i-1];
            addr_pipe_q[i] <= addr_pipe_q[i-1];
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        act_d    = act_q;
        mask_d   = mask_q;
        aw_d     = aw_q;
        cnt_d    = cnt_q;
        if (wr_edge) begin
            shadow_d[addr_dly] = din_dly;
            mask_d[addr_dly]   = 1'b1;
            cnt_d              = cnt_q + 8'd1;
            aw_d               = aw_q | (&mask_d);
        end
        // Load from the post-write bank so a coincident write is included
        if (ld_edge) begin
            act_d = shadow_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= {4{RESET_VAL}};
            act_q    <= {4{RESET_VAL}};
            mask_q   <= '0;
            aw_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            act_q    <= act_d;
            mask_q   <= mask_d;
            aw_q     <= aw_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.q0          = act_q[0];
    assign bus.q1          = act_q[1];
    assign bus.q2          = act_q[2];
    assign bus.q3          = act_q[3];
    assign bus.all_written = aw_q;
    assign bus.wr_cnt      = cnt_q;

`ifdef CFG_DEMUX_READBACK_EN
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= shadow_q[addr_dly];
        end
    end

    assign bus.rd_data = rd_q;
`else
    assign bus.rd_data = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_cfg_demux.sv
module tb_cfg_demux;
    localparam int S = 2;

    logic clk;
    logic rst_n;

    cfg_demux_if #(.DATA_W(8)) bus();

    cfg_demux #(.DATA_W(8), .SYNC_STAGES(S), .RESET_VAL(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  compared   = 0;
    int  mismatched = 0;

    // reference model state
    logic [7:0] sh [4];
    logic [7:0] mq [4];
    logic [7:0] cnt;
    logic [3:0] wmask;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        sb_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_t e;
        compared++;
        if (sb_q.size() == 0) begin
            mismatched++;
            $error("FAIL sb_empty observed=%h expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                mismatched++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    function automatic logic [31:0] dut_bank();
        return {bus.q3, bus.q2, bus.q1, bus.q0};
    endfunction

    function automatic logic [31:0] model_bank();
        return {mq[3], mq[2], mq[1], mq[0]};
    endfunction

    function automatic logic [31:0] shadow_bank();
        return {sh[3], sh[2], sh[1], sh[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            sh[i] = 8'h00;
            mq[i] = 8'h00;
        end
        cnt   = 8'd0;
        wmask = 4'b0;
    endtask

    task automatic check_reset_state(input string tag);
        sb_push({tag, "_q"}, 32'h0);
        sb_check(dut_bank());
        sb_push({tag, "_aw"}, 32'h0);
        sb_check({31'b0, bus.all_written});
        sb_push({tag, "_cnt"}, 32'h0);
        sb_check({24'b0, bus.wr_cnt});
    endtask

    // Single write pulse; wr_cnt must still be old after S edges, new at S+1
    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        bus.din    = d;
        bus.addr   = a;
        bus.wr_stb = 1'b1;
        sb_push("wr_cnt_pre", {24'b0, cnt});
        tick(S);
        sb_check({24'b0, bus.wr_cnt});
        sh[a]    = d;
        wmask[a] = 1'b1;
        cnt      = cnt + 8'd1;
        sb_push("wr_cnt_post", {24'b0, cnt});
        tick(1);
        sb_check({24'b0, bus.wr_cnt});
        bus.wr_stb = 1'b0;
        tick(S + 1);
    endtask

    // Load pulse; bank unchanged after S edges, whole new bank at S+1
    task automatic do_load(input string tag);
        bus.ld_stb = 1'b1;
        sb_push({tag, "_pre"}, model_bank());
        tick(S);
        sb_check(dut_bank());
        for (int i = 0; i < 4; i++) mq[i] = sh[i];
        sb_push({tag, "_post"}, model_bank());
        tick(1);
        sb_check(dut_bank());
        bus.ld_stb = 1'b0;
        tick(S + 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.din    = 8'h00;
        bus.addr   = 2'd0;
        bus.wr_stb = 1'b0;
        bus.ld_stb = 1'b0;
        model_reset();

        // Reset values visible before any clock edge
        #2;
        check_reset_state("rst_async0");
        sb_push("rst_rd", 32'h0);
        sb_check({24'b0, bus.rd_data});
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // Write A5 to addr 2, then load
        do_write(2'd2, 8'hA5);
        sb_push("t2_q_before_load", 32'h0);
        sb_check(dut_bank());
        sb_push("t2_aw_low", 32'h0);
        sb_check({31'b0, bus.all_written});
        do_load("t2_load");

        // Mid-clock reset with wr_stb held high across release
        #3;
        rst_n      = 1'b0;
        bus.wr_stb = 1'b1;
        bus.din    = 8'hEE;
        bus.addr   = 2'd0;
        #1;
        model_reset();
        check_reset_state("rst_mid");
        #2;
        rst_n = 1'b1;
        tick(S + 4);
        sb_push("held_thru_reset_cnt", 32'h0);
        sb_check({24'b0, bus.wr_cnt});
        bus.wr_stb = 1'b0;
        tick(S + 2);

        // Program all four bytes
        do_write(2'd0, 8'h11);
        do_write(2'd1, 8'h22);
        do_write(2'd2, 8'h33);
        sb_push("t3_aw_after3", 32'h0);
        sb_check({31'b0, bus.all_written});
        do_write(2'd3, 8'h44);
        sb_push("t3_aw_after4", {31'b0, &wmask});
        sb_check({31'b0, bus.all_written});
        sb_push("t3_cnt4", 32'd4);
        sb_check({24'b0, bus.wr_cnt});
        do_load("t3_load");
        sb_push("t3_aw_after_load", 32'h1);
        sb_check({31'b0, bus.all_written});

        // Readback of addr 2 (previous addr_d was 3)
        bus.addr = 2'd2;
        tick(S);
`ifdef CFG_DEMUX_READBACK_EN
        sb_push("rd_prev_addr", {24'b0, sh[3]});
`else
        sb_push("rd_prev_addr", 32'h0);
`endif
        sb_check({24'b0, bus.rd_data});
        tick(1);
`ifdef CFG_DEMUX_READBACK_EN
        sb_push("rd_addr2", {24'b0, sh[2]});
`else
        sb_push("rd_addr2", 32'h0);
`endif
        sb_check({24'b0, bus.rd_data});

        // Hold wr_stb high for 10 cycles: exactly one write
        bus.din    = 8'h7E;
        bus.addr   = 2'd1;
        bus.wr_stb = 1'b1;
        tick(10);
        bus.wr_stb = 1'b0;
        tick(S + 1);
        sh[1] = 8'h7E;
        cnt   = cnt + 8'd1;
        sb_push("t4_hold_cnt", {24'b0, cnt});
        sb_check({24'b0, bus.wr_cnt});
        sb_push("t4_q_unchanged", model_bank());
        sb_check(dut_bank());
        sb_push("t4_shadow_other", 32'h4433_7E11);
        sb_check(shadow_bank());

        // Write and load on the same edge: load picks up the new byte
        bus.din    = 8'h5A;
        bus.addr   = 2'd3;
        bus.wr_stb = 1'b1;
        bus.ld_stb = 1'b1;
        sb_push("t5_pre", model_bank());
        tick(S);
        sb_check(dut_bank());
        sh[3] = 8'h5A;
        cnt   = cnt + 8'd1;
        for (int i = 0; i < 4; i++) mq[i] = sh[i];
        sb_push("t5_post", 32'h5A33_7E11);
        tick(1);
        sb_check(dut_bank());
        sb_push("t5_cnt", {24'b0, cnt});
        sb_check({24'b0, bus.wr_cnt});
        bus.wr_stb = 1'b0;
        bus.ld_stb = 1'b0;
        tick(S + 2);
        sb_push("t5_q_stable", model_bank());
        sb_check(dut_bank());

        // Final asynchronous reset clears a populated bank
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_state("rst_final");
        sb_push("rst_final_rd", 32'h0);
        sb_check({24'b0, bus.rd_data});
        #2;
        rst_n = 1'b1;
        tick(2);

        if (sb_q.size() != 0) begin
            compared++;
            mismatched++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
